// File: rtl/cfu_initiator_if.sv
// rtl/cfu_initiator_if.sv - CFU command/response handshake bundle
interface cfu_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  modport master (
    output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_payload_outputs_0
  );

  modport slave (
    input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, rsp_ready,
    output cmd_ready, rsp_valid, rsp_payload_outputs_0
  );
endinterface

// File: rtl/cfu_initiator.sv
// rtl/cfu_initiator.sv - CFU write-then-readback pattern tester
// Writes seed+i to a run of word addresses, reads them back, counts mismatches.
module cfu_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [9:0]  FUNC_WRITE     = 10'd1,
  parameter logic [9:0]  FUNC_READ      = 10'd0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [13:0]            base_addr,
  input  logic [14:0]            count,
  input  logic [31:0]            seed,
  cfu_initiator_if.master        cfu,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            err_count,
  output logic                   timeout_err,
  output logic [14:0]            first_fail_idx
);

  typedef enum logic [2:0] {IDLE, WR_CMD, WR_RSP, RD_CMD, RD_RSP, FINISH} state_t;

  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYCLES);
  localparam logic [14:0] NO_FAIL = 15'h7FFF;

  state_t      state_q, state_d;
  logic [13:0] base_q, base_d;
  logic [14:0] cnt_q, cnt_d;
  logic [31:0] seed_q, seed_d;
  logic [14:0] idx_q, idx_d;
  logic [15:0] tmo_q, tmo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] err_q, err_d;
  logic        tmo_err_q, tmo_err_d;
  logic [14:0] ffi_q, ffi_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [9:0]  fid_q, fid_d;
  logic [31:0] in0_q, in0_d;
  logic [31:0] in1_q, in1_d;
  logic        rsp_ready_q, rsp_ready_d;

  logic [14:0] idx_inc;
  logic [31:0] cur_pat;
  logic [31:0] nxt_pat;
  logic [13:0] nxt_addr;
  logic        cmd_fire;
  logic        rsp_fire;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    seed_d    = seed_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    tmo_err_d = tmo_err_q;
    ffi_d     = ffi_q;
    idx_inc   = idx_q + 15'd1;
    cur_pat   = seed_q + {17'd0, idx_q};
    cmd_fire  = cmd_valid_q & cfu.cmd_ready;
    rsp_fire  = rsp_ready_q & cfu.rsp_valid;

    unique case (state_q)
      IDLE: begin
        // busy_q still high here means the done cycle; a start then is ignored
        if (start && !busy_q) begin
          base_d    = base_addr;
          cnt_d     = count;
          seed_d    = seed;
          idx_d     = 15'd0;
          err_d     = 16'd0;
          tmo_err_d = 1'b0;
          ffi_d     = NO_FAIL;
          state_d   = (count == 15'd0) ? FINISH : WR_CMD;
        end
      end
      WR_CMD: begin
        if (cmd_fire) begin
          tmo_d   = 16'd0;
          state_d = WR_RSP;
        end
      end
      WR_RSP: begin
        if (rsp_fire) begin
          if (idx_inc == cnt_q) begin
            idx_d   = 15'd0;
            state_d = RD_CMD;
          end else begin
            idx_d   = idx_inc;
            state_d = WR_CMD;
          end
        end else if (tmo_q + 16'd1 == TMO_LIM) begin
          tmo_err_d = 1'b1;
          state_d   = FINISH;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      RD_CMD: begin
        if (cmd_fire) begin
          tmo_d   = 16'd0;
          state_d = RD_RSP;
        end
      end
      RD_RSP: begin
        if (rsp_fire) begin
          if (cfu.rsp_payload_outputs_0 != {cur_pat[15:0], cur_pat[15:0]}) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (ffi_q == NO_FAIL) ffi_d = idx_q;
          end
          idx_d   = idx_inc;
          state_d = (idx_inc == cnt_q) ? FINISH : RD_CMD;
        end else if (tmo_q + 16'd1 == TMO_LIM) begin
          tmo_err_d = 1'b1;
          state_d   = FINISH;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next-state view so they line up with state_q
    nxt_addr    = base_d + idx_d[13:0];
    nxt_pat     = seed_d + {17'd0, idx_d};
    cmd_valid_d = (state_d == WR_CMD) || (state_d == RD_CMD);
    rsp_ready_d = (state_d == WR_RSP) || (state_d == RD_RSP);
    fid_d       = 10'd0;
    in0_d       = 32'd0;
    in1_d       = 32'd0;
    if (state_d == WR_CMD) begin
      fid_d = FUNC_WRITE;
      in0_d = {18'd0, nxt_addr};
      in1_d = nxt_pat;
    end else if (state_d == RD_CMD) begin
      fid_d = FUNC_READ;
      in0_d = {18'd0, nxt_addr};
      in1_d = {18'd0, nxt_addr};
    end
    done_d = (state_q == FINISH);
    busy_d = (state_d != IDLE) || (state_q == FINISH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      base_q      <= 14'd0;
      cnt_q       <= 15'd0;
      seed_q      <= 32'd0;
      idx_q       <= 15'd0;
      tmo_q       <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 16'd0;
      tmo_err_q   <= 1'b0;
      ffi_q       <= NO_FAIL;
      cmd_valid_q <= 1'b0;
      fid_q       <= 10'd0;
      in0_q       <= 32'd0;
      in1_q       <= 32'd0;
      rsp_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      seed_q      <= seed_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tmo_err_q   <= tmo_err_d;
      ffi_q       <= ffi_d;
      cmd_valid_q <= cmd_valid_d;
      fid_q       <= fid_d;
      in0_q       <= in0_d;
      in1_q       <= in1_d;
      rsp_ready_q <= rsp_ready_d;
    end
  end

  assign cfu.cmd_valid               = cmd_valid_q;
  assign cfu.cmd_payload_function_id = fid_q;
  assign cfu.cmd_payload_inputs_0    = in0_q;
  assign cfu.cmd_payload_inputs_1    = in1_q;
  assign cfu.rsp_ready               = rsp_ready_q;
  assign busy                        = busy_q;
  assign done                        = done_q;
  assign err_count                   = err_q;
  assign timeout_err                 = tmo_err_q;
  assign first_fail_idx              = ffi_q;

endmodule

// File: tb/tb_cfu_initiator.sv
// tb/tb_cfu_initiator.sv - self-checking bench for cfu_initiator
// A CFU memory model answers commands; expectations come from per-run arithmetic.
module tb_cfu_initiator;
  localparam logic [9:0] F_WR  = 10'd1;
  localparam logic [9:0] F_RD  = 10'd0;
  localparam int         T_OUT = 255;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [13:0] base_addr;
  logic [14:0] count;
  logic [31:0] seed;
  logic        busy;
  logic        done;
  logic [15:0] err_count;
  logic        timeout_err;
  logic [14:0] first_fail_idx;

  cfu_initiator_if cfu_bus ();

  cfu_initiator dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .count          (count),
    .seed           (seed),
    .cfu            (cfu_bus),
    .busy           (busy),
    .done           (done),
    .err_count      (err_count),
    .timeout_err    (timeout_err),
    .first_fail_idx (first_fail_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks;
  int failures;

  // Model configuration, written only by the stimulus block
  int          rsp_delay;
  int          ready_stall;
  logic [31:0] corrupt_mask;
  int          flush_req;

  // Model observations, written only by the model block
  int          flush_ack;
  int          wr_ptr;
  int          done_cnt;
  int          stall_cycles;
  int          unstable;
  int          overlap;
  logic [9:0]  log_fid [0:4095];
  logic [31:0] log_a   [0:4095];
  logic [31:0] log_d   [0:4095];
  logic [31:0] mem     [0:16383];

  initial begin : cfu_model
    bit          pend, cfire, rfire, prev_stall;
    int          wait_left, stall_left, rd_seen;
    logic [31:0] pend_data, pa, pd;
    logic [9:0]  pfid;
    flush_ack = 0; wr_ptr = 0; done_cnt = 0; stall_cycles = 0; unstable = 0; overlap = 0;
    pend = 0; prev_stall = 0; wait_left = 0; stall_left = 0; rd_seen = 0;
    pend_data = 0; pa = 0; pd = 0; pfid = 0;
    cfu_bus.cmd_ready = 1'b1;
    cfu_bus.rsp_valid = 1'b0;
    cfu_bus.rsp_payload_outputs_0 = 32'd0;
    forever begin
      @(negedge clk);
      cfire = cfu_bus.cmd_valid && cfu_bus.cmd_ready;
      rfire = cfu_bus.rsp_valid && cfu_bus.rsp_ready;
      if (done) done_cnt++;
      if (cfu_bus.cmd_valid && cfu_bus.rsp_ready) overlap++;
      if (prev_stall && (!cfu_bus.cmd_valid ||
          {cfu_bus.cmd_payload_function_id, cfu_bus.cmd_payload_inputs_0, cfu_bus.cmd_payload_inputs_1} != {pfid, pa, pd}))
        unstable++;
      prev_stall = cfu_bus.cmd_valid && !cfu_bus.cmd_ready;
      if (prev_stall) stall_cycles++;
      pfid = cfu_bus.cmd_payload_function_id;
      pa   = cfu_bus.cmd_payload_inputs_0;
      pd   = cfu_bus.cmd_payload_inputs_1;
      if (cfire) begin
        log_fid[wr_ptr & 4095] = pfid;
        log_a[wr_ptr & 4095]   = pa;
        log_d[wr_ptr & 4095]   = pd;
        wr_ptr++;
        if (pfid == F_WR) begin
          mem[pa[13:0]] = pd;
          pend_data = 32'd0;
          rd_seen = 0;
        end else begin
          pend_data = {mem[pa[13:0]][15:0], mem[pa[13:0]][15:0]};
          if (rd_seen < 32 && corrupt_mask[rd_seen]) pend_data ^= 32'h1;
          rd_seen++;
        end
        pend = 1;
        wait_left = rsp_delay;
      end
      @(posedge clk);
      #2;
      if (rfire) cfu_bus.rsp_valid = 1'b0;
      if (cfire) stall_left = ready_stall;
      else if (prev_stall && stall_left > 0) stall_left--;
      if (flush_req != flush_ack) begin
        flush_ack = flush_req;
        pend = 0;
        cfu_bus.rsp_valid = 1'b0;
        stall_left = ready_stall;
      end else if (pend) begin
        if (wait_left == 0) begin
          cfu_bus.rsp_valid = 1'b1;
          cfu_bus.rsp_payload_outputs_0 = pend_data;
          pend = 0;
        end else begin
          wait_left--;
        end
      end
      cfu_bus.cmd_ready = (stall_left == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_case(input string tag, input logic [13:0] b, input logic [14:0] n,
                          input logic [31:0] s, input int dly, input int stl,
                          input logic [31:0] cmask, input bit mid, input bit exp_to);
    int          w0, d0, st0, ni, exp_k, exp_cmds, exp_err, done_at, got, i, ai, li;
    logic [14:0] exp_ffi;
    logic [9:0]  efid;
    logic [31:0] ed;
    rsp_delay = dly; ready_stall = stl; corrupt_mask = cmask; flush_req++;
    @(posedge clk); #1;
    w0 = wr_ptr; d0 = done_cnt; st0 = stall_cycles;
    ni = int'(n);
    exp_cmds = exp_to ? 1 : 2 * ni;
    exp_k    = exp_to ? 3 + stl + T_OUT : 2 + 2 * ni * (2 + dly + stl);
    exp_err  = 0;
    exp_ffi  = 15'h7FFF;
    for (int k = 0; k < ni; k++) begin
      if (!exp_to && k < 32 && cmask[k]) begin
        exp_err++;
        if (exp_ffi == 15'h7FFF) exp_ffi = 15'(k);
      end
    end
    base_addr = b; count = n; seed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_at = 0;
    for (int k = 1; k <= exp_k + 40; k++) begin
      @(negedge clk); #1;
      if (mid && k == 3) begin
        base_addr = 14'h1234; count = 15'd7; seed = 32'hDEAD_BEEF; start = 1'b1;
      end
      if (mid && k == 4) start = 1'b0;
      if (done === 1'b1) begin
        done_at = k;
        break;
      end
    end
    chk({tag, "_done_latency"}, 32'(done_at), 32'(exp_k));
    chk({tag, "_busy_during_done"}, 32'(busy), 32'd1);
    @(negedge clk); #1;
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_done_width"}, 32'(done), 32'd0);
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    got = wr_ptr - w0;
    chk({tag, "_cmd_count"}, 32'(got), 32'(exp_cmds));
    for (int j = 0; j < exp_cmds && j < got; j++) begin
      i    = (j < ni) ? j : j - ni;
      ai   = (int'(b) + i) % 16384;
      efid = (j < ni) ? F_WR : F_RD;
      ed   = (j < ni) ? s + 32'(i) : 32'(ai);
      li   = (w0 + j) & 4095;
      chk({tag, "_fid"}, 32'(log_fid[li]), 32'(efid));
      chk({tag, "_addr"}, log_a[li], 32'(ai));
      chk({tag, "_data"}, log_d[li], ed);
    end
    chk({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
    chk({tag, "_first_fail"}, 32'(first_fail_idx), 32'(exp_ffi));
    chk({tag, "_timeout"}, 32'(timeout_err), 32'(exp_to));
    chk({tag, "_stall_cycles"}, 32'(stall_cycles - st0), 32'(stl * exp_cmds));
    chk({tag, "_payload_stable"}, 32'(unstable), 32'd0);
    chk({tag, "_one_outstanding"}, 32'(overlap), 32'd0);
  endtask

  initial begin : stim
    int  w0, d0;
    bit  found, saw_rsp, activity;
    checks = 0; failures = 0;
    reset_n = 1'b0; start = 1'b0; base_addr = 14'd0; count = 15'd0; seed = 32'd0;
    rsp_delay = 0; ready_stall = 0; corrupt_mask = 32'd0; flush_req = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cmd_valid", 32'(cfu_bus.cmd_valid), 32'd0);
    chk("rst_rsp_ready", 32'(cfu_bus.rsp_ready), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_first_fail", 32'(first_fail_idx), 32'h7FFF);
    @(posedge clk); #1;
    reset_n = 1'b1;

    run_case("basic", 14'h0010, 15'd4, 32'h0000_1000, 0, 0, 32'd0, 1'b0, 1'b0);
    run_case("wrap", 14'h3FFE, 15'd4, $urandom, 1, 0, 32'd0, 1'b0, 1'b0);
    run_case("corrupt", 14'h0020, 15'd4, $urandom, 0, 0, 32'hC, 1'b0, 1'b0);
    run_case("stall_tmo", 14'h0100, 15'd4, $urandom, 400, 5, 32'd0, 1'b0, 1'b1);
    run_case("rsp_at_limit", 14'h0200, 15'd1, $urandom, 254, 0, 32'd0, 1'b0, 1'b0);
    run_case("rsp_past_limit", 14'h0210, 15'd2, $urandom, 255, 0, 32'd0, 1'b0, 1'b1);
    run_case("zero", 14'h0055, 15'd0, $urandom, 0, 0, 32'd0, 1'b0, 1'b0);
    run_case("mid_start", 14'h0300, 15'd4, $urandom, 1, 1, 32'h2, 1'b1, 1'b0);
    for (int r = 0; r < 8; r++) begin
      run_case($sformatf("rand%0d", r), 14'($urandom), 15'($urandom_range(1, 12)), $urandom,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom, 1'b0, 1'b0);
    end

    // Reset while a read response is outstanding
    rsp_delay = 20; ready_stall = 0; corrupt_mask = 32'd0; flush_req++;
    @(posedge clk); #1;
    w0 = wr_ptr;
    base_addr = 14'h0400; count = 15'd4; seed = $urandom; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      if (wr_ptr - w0 == 5) begin
        found = 1;
        break;
      end
    end
    chk("rst_mid_reached_read", 32'(found), 32'd1);
    @(posedge clk); #3;
    chk("rst_mid_rsp_ready_before", 32'(cfu_bus.rsp_ready), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_cmd_valid", 32'(cfu_bus.cmd_valid), 32'd0);
    chk("rst_mid_rsp_ready", 32'(cfu_bus.rsp_ready), 32'd0);
    chk("rst_mid_err", 32'(err_count), 32'd0);
    chk("rst_mid_timeout", 32'(timeout_err), 32'd0);
    chk("rst_mid_first_fail", 32'(first_fail_idx), 32'h7FFF);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    d0 = done_cnt;
    saw_rsp = 0; activity = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (cfu_bus.rsp_valid) saw_rsp = 1;
      if (busy || done || cfu_bus.rsp_ready || cfu_bus.cmd_valid) activity = 1;
    end
    chk("rst_late_rsp_seen", 32'(saw_rsp), 32'd1);
    chk("rst_late_rsp_ignored", 32'(activity), 32'd0);
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
    run_case("post_rst", 14'h0400, 15'd4, $urandom, 0, 0, 32'h1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cfu_initiator.md
CFU_INITIATOR -- requirements
Module: cfu_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles waiting for a response before abort.
REQ-002 Parameter FUNC_WRITE, default 10'd1, function_id used for write commands.
REQ-003 Parameter FUNC_READ, default 10'd0, function_id used for read commands.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse; begins a run when idle.
REQ-007 base_addr  in  14  first word address of the run.
REQ-008 count  in  15  number of words, range 0..16384.
REQ-009 seed  in  32  data pattern base.
REQ-010 cmd_valid  out  1  command offered to CFU.
REQ-011 cmd_ready  in  1  CFU accepts command.
REQ-012 cmd_payload_function_id  out  10  command opcode.
REQ-013 cmd_payload_inputs_0  out  32  word address, zero-extended from 14 bits.
REQ-014 cmd_payload_inputs_1  out  32  write data or read operand.
REQ-015 rsp_valid  in  1  CFU response present.
REQ-016 rsp_ready  out  1  initiator accepts response.
REQ-017 rsp_payload_outputs_0  in  32  response data.
REQ-018 busy  out  1  run in progress.
REQ-019 done  out  1  one-cycle pulse at run end.
REQ-020 err_count  out  16  read mismatches in last run, saturating.
REQ-021 timeout_err  out  1  last run aborted by timeout.
REQ-022 first_fail_idx  out  15  index of first mismatch; 0x7FFF if none.

Function
REQ-023 States: IDLE, WR_CMD, WR_RSP, RD_CMD, RD_RSP, FINISH.
REQ-024 IDLE: start=1 latches base_addr, count, seed; clears err_count, timeout_err, first_fail_idx=0x7FFF, index=0; goes WR_CMD, or FINISH if count==0.
REQ-025 start while busy=1 is ignored with no effect on the run.
REQ-026 Address for index i = (base_addr + i) mod 2^14; wrap past 0x3FFF to 0x0000.
REQ-027 Pattern for index i = seed + i, 32-bit modulo.
REQ-028 WR_CMD: cmd_valid=1, function_id=FUNC_WRITE, inputs_0=address, inputs_1=pattern; on cmd_valid&cmd_ready go WR_RSP.
REQ-029 Payload and cmd_valid hold stable while cmd_valid=1 and cmd_ready=0.
REQ-030 Exactly one command outstanding; cmd_valid=0 in every *_RSP state.
REQ-031 rsp_ready=1 only in WR_RSP and RD_RSP; responses arriving in other states are ignored.
REQ-032 WR_RSP: response data discarded; on rsp_valid: index+1; if index+1==count reset index to 0 and go RD_CMD, else WR_CMD.
REQ-033 RD_CMD: function_id=FUNC_READ, inputs_0=address, inputs_1=address zero-extended; transfer rule as WR_CMD; go RD_RSP.
REQ-034 RD_RSP: on rsp_valid compare rsp_payload_outputs_0 to {pattern[15:0], pattern[15:0]}; mismatch increments err_count (saturate 0xFFFF) and sets first_fail_idx if still 0x7FFF.
REQ-035 RD_RSP advance: index+1; index+1==count goes FINISH, else RD_CMD.
REQ-036 Timeout counter clears on entry to each *_RSP state, increments each cycle without rsp_valid; reaching TIMEOUT_CYCLES sets timeout_err=1 and goes FINISH.
REQ-037 Response and timeout in same cycle: response wins.
REQ-038 Command and response on same cycle impossible by REQ-030; cmd_ready high with cmd_valid low has no effect.
REQ-039 FINISH: done=1 for one cycle, busy=0 next cycle, return IDLE; results hold until next start.
REQ-040 busy=1 in all states except IDLE.
REQ-041 Latency per word: 1 cycle command minimum plus CFU response latency; minimum 2 cycles per command with cmd_ready and rsp_valid returning immediately.

Reset
REQ-042 reset_n=0 asynchronously forces IDLE; cmd_valid=0, rsp_ready=0, busy=0, done=0, err_count=0, timeout_err=0, first_fail_idx=0x7FFF, index=0.
REQ-043 Reset mid-run abandons the run; no done pulse; an outstanding CFU response after reset release is ignored.

Verification
REQ-044 base=0x0010, count=4, seed=0x00001000, ideal memory model, 1-cycle rsp -> writes 0x1000..0x1003 to 0x10..0x13, then 4 reads, done pulse, err_count=0, first_fail_idx=0x7FFF.
REQ-045 base=0x3FFE, count=4 -> addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001 in both phases.
REQ-046 Model corrupts read of index 2 and 3 -> err_count=2, first_fail_idx=2.
REQ-047 cmd_ready low for 5 cycles on first write -> payload stable all 5 cycles, single transfer; rsp withheld 255 cycles -> timeout_err=1, done pulse, busy=0.
REQ-048 count=0 -> no cmd_valid, done pulse 2 cycles after start; start during run ignored.
REQ-049 reset_n low during RD_RSP -> all outputs at REQ-042 values immediately; late rsp_valid ignored; next start runs cleanly.
